l2_wcb: RTL

L2_WCB -- requirements
Module: l2_wcb

---
 rtl/l2_wcb_if.sv | 41 ++++
 rtl/l2_wcb.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/l2_wcb_if.sv
// rtl/l2_wcb_if.sv - bus bundle for the L2 write-combining buffer
interface l2_wcb_if #(
    parameter int N_WB   = 4,
    parameter int WORDS  = 2,
    parameter int WORD_W = 64,
    parameter int ADDR_W = 28
);
    localparam int WOFF_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W  = $clog2(N_WB) + 1;
    localparam int LINE_W = WORDS * WORD_W;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [WOFF_W-1:0] wr_woff;
    logic [WORD_W-1:0] wr_word;
    logic [ADDR_W-1:0] lk_addr;
    logic              lk_hit;
    logic [WORDS-1:0]  lk_mask;
    logic [LINE_W-1:0] lk_line;
    logic              drain_valid;
    logic              drain_ready;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [LINE_W-1:0] out_line;
    logic [WORDS-1:0]  out_mask;
    logic [CNT_W-1:0]  count;
    logic              empty;

    modport master (
        output wr_valid, wr_addr, wr_woff, wr_word, lk_addr, drain_valid, out_ready,
        input  wr_ready, lk_hit, lk_mask, lk_line, drain_ready, out_valid,
               out_addr, out_line, out_mask, count, empty
    );
    modport slave (
        input  wr_valid, wr_addr, wr_woff, wr_word, lk_addr, drain_valid, out_ready,
        output wr_ready, lk_hit, lk_mask, lk_line, drain_ready, out_valid,
               out_addr, out_line, out_mask, count, empty
    );
endinterface

// File: rtl/l2_wcb.sv
// rtl/l2_wcb.sv - L2 write-combining buffer: circular FIFO of partial lines with coalescing
module l2_wcb #(
    parameter int N_WB    = 4,
    parameter int WORDS   = 2,
    parameter int WORD_W  = 64,
    parameter int ADDR_W  = 28,
    parameter int THRESH  = N_WB - 1,
    parameter int TIMEOUT = 64
) (
    input logic      clk,
    input logic      rst,
    l2_wcb_if.slave  bus
);
    localparam int PTR_W  = $clog2(N_WB);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LINE_W = WORDS * WORD_W;
    localparam int WOFF_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [N_WB-1:0]   ent_valid;
    logic [ADDR_W-1:0] ent_addr [N_WB];
    logic [WORDS-1:0]  ent_mask [N_WB];
    logic [LINE_W-1:0] ent_line [N_WB];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic [IDLE_W-1:0] idle_cnt;
    logic              out_valid_q;

    logic              co_hit;
    logic [PTR_W-1:0]  co_idx;
    logic [WORDS-1:0]  new_mask;
    logic [LINE_W-1:0] new_line, new_keep;
    logic              wr_ready, wr_fire, alloc, hs, dispatch;
    logic              lk_hit;
    logic [WORDS-1:0]  lk_mask;
    logic [LINE_W-1:0] lk_line;
    logic [PTR_W-1:0]  lk_idx;

    // The head is frozen while it is being offered, so writes to its address open a new entry.
    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        for (int i = 0; i < N_WB; i++) begin
            if (ent_valid[i] && ent_addr[i] == bus.wr_addr &&
                !(out_valid_q && PTR_W'(i) == head)) begin
                co_hit = 1'b1;
                co_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        new_mask = '0;
        new_line = '0;
        new_keep = '1;
        for (int w = 0; w < WORDS; w++) begin
            if (bus.wr_woff == WOFF_W'(w)) begin
                new_mask[w]                  = 1'b1;
                new_line[w*WORD_W +: WORD_W] = bus.wr_word;
                new_keep[w*WORD_W +: WORD_W] = '0;
            end
        end
    end

    assign wr_ready = (state_q == IDLE) && (co_hit || count < CNT_W'(N_WB));
    assign wr_fire  = bus.wr_valid && wr_ready;
    assign alloc    = wr_fire && !co_hit;
    assign hs       = out_valid_q && bus.out_ready;
    assign dispatch = (count != '0) &&
                      (state_q == DRAIN || count >= CNT_W'(THRESH) || idle_cnt == IDLE_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid   <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            idle_cnt    <= '0;
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_q ? !hs : dispatch;
            count       <= count + CNT_W'(alloc) - CNT_W'(hs);
            if (wr_fire)
                idle_cnt <= '0;
            else if (idle_cnt < IDLE_W'(TIMEOUT))
                idle_cnt <= idle_cnt + 1'b1;
            if (hs) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            if (alloc) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            if (co_hit) begin
                ent_mask[co_idx] <= ent_mask[co_idx] | new_mask;
                ent_line[co_idx] <= (ent_line[co_idx] & new_keep) | new_line;
            end else begin
                ent_addr[tail] <= bus.wr_addr;
                ent_mask[tail] <= new_mask;
                ent_line[tail] <= new_line;
            end
        end
    end

    // Walk oldest to youngest so the youngest matching entry overrides older ones.
    always_comb begin
        lk_hit  = 1'b0;
        lk_mask = '0;
        lk_line = '0;
        lk_idx  = '0;
        for (int i = 0; i < N_WB; i++) begin
            lk_idx = head + PTR_W'(i);
            if (ent_valid[lk_idx] && ent_addr[lk_idx] == bus.lk_addr) begin
                lk_hit  = 1'b1;
                lk_mask = ent_mask[lk_idx];
                lk_line = ent_line[lk_idx];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.drain_valid) state_d = DRAIN;
            DRAIN:   if (count == '0 && !out_valid_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.wr_ready    = wr_ready;
    assign bus.lk_hit      = lk_hit;
    assign bus.lk_mask     = lk_mask;
    assign bus.lk_line     = lk_line;
    assign bus.drain_ready = (state_q == DONE);
    assign bus.out_valid   = out_valid_q;
    assign bus.out_addr    = ent_addr[head];
    assign bus.out_mask    = ent_mask[head];
    assign bus.out_line    = ent_line[head];
    assign bus.count       = count;
    assign bus.empty       = (count == '0);
endmodule
